// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath: default widths, butterfly slot encoding and
// modular add/sub helpers used by the butterfly.
package ntt_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_Q      = 12289;

   // Generator rhythm: read upper, read lower, write upper, write lower.
   typedef enum logic [1:0] {
      SLOT_RD_HI,
      SLOT_RD_LO,
      SLOT_WR_HI,
      SLOT_WR_LO
   } slot_e;

   function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, q}) begin
         sum = sum - {1'b0, q};
      end
      return 32'(sum);
   endfunction

   function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
      logic signed [33:0] diff;
      diff = $signed({2'b00, a}) - $signed({2'b00, b});
      if (diff < 0) begin
         diff = diff + $signed({2'b00, q});
      end
      return 32'(diff);
   endfunction

endpackage

// File: rtl/ntt_mod_mul.sv
// Registered modular multiplier: p = (a * b) mod Q, one cycle of latency.
module ntt_mod_mul
   import ntt_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned Q      = DEF_Q
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] p
);

   localparam logic [2*DATA_W-1:0] QWide = (2*DATA_W)'(Q);

   logic [2*DATA_W-1:0] prod;

   assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

   // Constant divisor, so the remainder reduces to fixed logic.
   always_ff @(posedge clk) begin
      if (!rst) begin
         p <= '0;
      end else begin
         p <= DATA_W'(prod % QWide);
      end
   end

endmodule

// File: rtl/ntt_butterfly.sv
// Radix-2 Cooley-Tukey butterfly following the address generator's 4-slot rhythm:
// captures B, w then A, and writes B' = A - wB and A' = A + wB (mod Q).
module ntt_butterfly
   import ntt_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned Q      = DEF_Q,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic [DATA_W-1:0] rd_data,
   input  logic [DATA_W-1:0] twiddle,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_valid,
   output logic              wr_sel,
   output logic              bfly_done,
   output logic [CNT_W-1:0]  bfly_count,
   output logic              range_err
);

   localparam logic [DATA_W-1:0] QNarrow = DATA_W'(Q);

   slot_e             slotQ, slotD, curSlot;
   logic [DATA_W-1:0] bQ, bD, wQ, wD, aQ, aD;
   logic [DATA_W-1:0] prodMod;
   logic [DATA_W-1:0] wrDataD;
   logic              wrValidD, wrSelD, doneD, rangeErrD;
   logic [CNT_W-1:0]  countD;

   ntt_mod_mul #(
      .DATA_W(DATA_W),
      .Q     (Q)
   ) uModMul (
      .clk(clk),
      .rst(rst),
      .a  (bQ),
      .b  (wQ),
      .p  (prodMod)
   );

   // sync overrides the counter so a partial butterfly is simply dropped.
   assign curSlot = sync ? SLOT_RD_HI : slotQ;

   always_comb begin
      slotD     = slotQ;
      bD        = bQ;
      wD        = wQ;
      aD        = aQ;
      wrDataD   = wr_data;
      wrSelD    = wr_sel;
      wrValidD  = 1'b0;
      doneD     = 1'b0;
      countD    = bfly_count;
      rangeErrD = range_err;
      if (en) begin
         unique case (curSlot)
            SLOT_RD_HI: begin
               slotD = SLOT_RD_LO;
               bD    = rd_data;
               wD    = twiddle;
               if (rd_data >= QNarrow || twiddle >= QNarrow) begin
                  rangeErrD = 1'b1;
               end
            end
            SLOT_RD_LO: begin
               slotD = SLOT_WR_HI;
               aD    = rd_data;
               if (rd_data >= QNarrow) begin
                  rangeErrD = 1'b1;
               end
            end
            SLOT_WR_HI: begin
               slotD    = SLOT_WR_LO;
               wrDataD  = DATA_W'(mod_sub(32'(aQ), 32'(prodMod), Q));
               wrSelD   = 1'b0;
               wrValidD = 1'b1;
            end
            SLOT_WR_LO: begin
               slotD    = SLOT_RD_HI;
               wrDataD  = DATA_W'(mod_add(32'(aQ), 32'(prodMod), Q));
               wrSelD   = 1'b1;
               wrValidD = 1'b1;
               doneD    = 1'b1;
               countD   = bfly_count + 1'b1;
            end
            default: slotD = SLOT_RD_HI;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slotQ      <= SLOT_RD_HI;
         bQ         <= '0;
         wQ         <= '0;
         aQ         <= '0;
         wr_data    <= '0;
         wr_valid   <= 1'b0;
         wr_sel     <= 1'b0;
         bfly_done  <= 1'b0;
         bfly_count <= '0;
         range_err  <= 1'b0;
      end else begin
         slotQ      <= slotD;
         bQ         <= bD;
         wQ         <= wD;
         aQ         <= aD;
         wr_data    <= wrDataD;
         wr_valid   <= wrValidD;
         wr_sel     <= wrSelD;
         bfly_done  <= doneD;
         bfly_count <= countD;
         range_err  <= rangeErrD;
      end
   end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed corner cases plus randomized butterflies
// compared against a plain-arithmetic modular reference.
module tb_ntt_butterfly;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned Q      = 12289;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              sync = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic [DATA_W-1:0] twiddle = '0;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_sel;
   logic              bfly_done;
   logic [CNT_W-1:0]  bfly_count;
   logic              range_err;

   int  nChecks = 0;
   int  nPass = 0;
   int  expCount = 0;
   bit  expRange = 1'b0;

   ntt_butterfly #(
      .DATA_W(DATA_W),
      .Q     (Q),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .rd_data   (rd_data),
      .twiddle   (twiddle),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_sel    (wr_sel),
      .bfly_done (bfly_done),
      .bfly_count(bfly_count),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      nChecks++;
      if (obs == exp) begin
         nPass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full butterfly with optional stalls before slot 2 and before slot 3.
   task automatic runBfly(input int b, input int a, input int w, input int stall1,
                          input int stall2, input bit chkData);
      longint p, bp, ap;
      p  = (longint'(w) * longint'(b)) % Q;
      bp = (longint'(a) - p + Q) % Q;
      ap = (longint'(a) + p) % Q;
      if (b >= Q || a >= Q || w >= Q) expRange = 1'b1;

      en = 1'b1; sync = 1'b1; rd_data = DATA_W'(b); twiddle = DATA_W'(w);
      step();
      check("slot0_valid", wr_valid, 0);
      check("slot0_done", bfly_done, 0);
      sync = 1'b0; rd_data = DATA_W'(a); twiddle = DATA_W'($urandom);
      step();
      for (int i = 0; i < stall1; i++) begin
         en = 1'b0; rd_data = DATA_W'($urandom);
         step();
         check("stall1_valid", wr_valid, 0);
      end
      en = 1'b1; rd_data = DATA_W'($urandom);
      step();
      check("wrhi_valid", wr_valid, 1);
      check("wrhi_sel", wr_sel, 0);
      if (chkData) check("wrhi_data", wr_data, bp);
      for (int i = 0; i < stall2; i++) begin
         en = 1'b0;
         step();
         check("stall2_valid", wr_valid, 0);
         check("stall2_sel_hold", wr_sel, 0);
         if (chkData) check("stall2_data_hold", wr_data, bp);
      end
      en = 1'b1;
      step();
      expCount++;
      check("wrlo_valid", wr_valid, 1);
      check("wrlo_sel", wr_sel, 1);
      check("wrlo_done", bfly_done, 1);
      if (chkData) check("wrlo_data", wr_data, ap);
      check("count", bfly_count, expCount % (1 << CNT_W));
      check("range_err", range_err, expRange);
      en = 1'b0;
      step();
      check("idle_valid", wr_valid, 0);
      check("idle_done", bfly_done, 0);
   endtask

   task automatic checkResetState(input string tag);
      check({tag, "_data"}, wr_data, 0);
      check({tag, "_valid"}, wr_valid, 0);
      check({tag, "_sel"}, wr_sel, 0);
      check({tag, "_done"}, bfly_done, 0);
      check({tag, "_count"}, bfly_count, 0);
      check({tag, "_range"}, range_err, 0);
   endtask

   initial begin
      int b, a, w;
      rst = 1'b0;
      step();
      step();
      checkResetState("init");
      rst = 1'b1;

      // Reset landing in slot 3 after a write already went out.
      en = 1'b1; sync = 1'b1; rd_data = 16'd3; twiddle = 16'd2;
      step();
      sync = 1'b0; rd_data = 16'd5;
      step();
      step();
      check("pre_rst_data", wr_data, 12288);
      rst = 1'b0;
      step();
      checkResetState("midrst");
      rst = 1'b1; en = 1'b0;
      expCount = 0; expRange = 1'b0;
      step();
      check("post_rst_valid", wr_valid, 0);

      runBfly(3, 5, 2, 0, 0, 1'b1);
      runBfly(1000, 12000, 1, 0, 0, 1'b1);
      runBfly(1, 0, 12288, 0, 0, 1'b1);
      runBfly(12288, 0, 12288, 0, 0, 1'b1);
      runBfly(3, 5, 2, 3, 0, 1'b1);
      runBfly(4321, 777, 9999, 0, 2, 1'b1);

      // Realign: sync arrives in what would be slot 2 of an abandoned butterfly.
      en = 1'b1; sync = 1'b1; rd_data = 16'd100; twiddle = 16'd200;
      step();
      sync = 1'b0; rd_data = 16'd300;
      step();
      runBfly(12288, 12288, 12288, 0, 0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         b = (n % 7 == 0) ? Q - 1 : int'($urandom_range(0, Q - 1));
         a = (n % 5 == 0) ? 0 : int'($urandom_range(0, Q - 1));
         w = int'($urandom_range(0, Q - 1));
         runBfly(b, a, w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
      end

      // Out-of-range operand sets a sticky error that only reset clears.
      runBfly(int'(Q), 5, 2, 0, 0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         runBfly(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
                 int'($urandom_range(0, Q - 1)), 0, 0, 1'b1);
      end
      runBfly(5, int'(Q) + 100, 7, 0, 0, 1'b0);
      rst = 1'b0;
      step();
      checkResetState("final_rst");
      rst = 1'b1;
      expCount = 0; expRange = 1'b0;
      runBfly(7, 11, 13, 0, 0, 1'b1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
